// File: rtl/apb_gpio_slave_if.sv
// APB4 bus bundle between a requester and the GPIO completer.
interface apb_gpio_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB4 GPIO completer: DOUT/DIR/DIN/IRQ_EN/IRQ_STAT registers, programmable wait states.
// Optional GPIO_PROT_CHECK_EN: unprivileged writes to DIR/IRQ_EN are rejected with PSLVERR.
module apb_gpio_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_gpio_slave_if.slave       bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [2:0] OffDout    = 3'd0;
  localparam logic [2:0] OffDir     = 3'd1;
  localparam logic [2:0] OffDin     = 3'd2;
  localparam logic [2:0] OffIrqEn   = 3'd3;
  localparam logic [2:0] OffIrqStat = 3'd4;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                  r_state;
  logic [2:0]              r_off;
  logic                    r_misal;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_strb;
  logic [3:0]              r_cnt;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;

  logic [GPIO_WIDTH-1:0]   r_dout, r_dir, r_irq_en, r_irq_stat;
  logic [GPIO_WIDTH-1:0]   r_sync1, r_sync2, r_sync3;
  logic                    r_irq;

  logic                    w_setup, w_misal, w_write, w_err, w_commit;
  logic [2:0]              w_off;
  logic [DATA_WIDTH-1:0]   w_rdata, w_bmask;
  logic [GPIO_WIDTH-1:0]   w_gmask, w_gdata, w_rise, w_clr;
  logic                    w_unused;

  assign w_setup = bus.PSEL & ~bus.PENABLE;

  // In IDLE the decode looks at the live bus so a zero-wait transfer can answer at once.
  assign w_off   = (r_state == StIdle) ? bus.PADDR[4:2] : r_off;
  assign w_misal = (r_state == StIdle) ? (bus.PADDR[1:0] != 2'b00) : r_misal;
  assign w_write = (r_state == StIdle) ? bus.PWRITE : r_write;

`ifdef GPIO_PROT_CHECK_EN
  logic r_priv;
  logic w_priv;
  assign w_priv = (r_state == StIdle) ? bus.PPROT[0] : r_priv;
  assign w_err  = w_misal | (w_off > OffIrqStat) | (w_write & (w_off == OffDin)) |
                  (w_write & ~w_priv & ((w_off == OffDir) | (w_off == OffIrqEn)));
`else
  assign w_err  = w_misal | (w_off > OffIrqStat) | (w_write & (w_off == OffDin));
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OffDout:    w_rdata[GPIO_WIDTH-1:0] = r_dout;
      OffDir:     w_rdata[GPIO_WIDTH-1:0] = r_dir;
      OffDin:     w_rdata[GPIO_WIDTH-1:0] = r_sync2;
      OffIrqEn:   w_rdata[GPIO_WIDTH-1:0] = r_irq_en;
      OffIrqStat: w_rdata[GPIO_WIDTH-1:0] = r_irq_stat;
      default:    w_rdata = '0;
    endcase
    if (w_err || w_write) w_rdata = '0;
  end

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < 4; b++) w_bmask[8*b +: 8] = {8{r_strb[b]}};
  end

  assign w_gmask  = w_bmask[GPIO_WIDTH-1:0];
  assign w_gdata  = r_wdata[GPIO_WIDTH-1:0];
  // PSLVERR is still asserted during DONE, so it doubles as the commit veto.
  assign w_commit = (r_state == StDone) & r_write & ~r_pslverr;
  assign w_rise   = r_sync2 & ~r_sync3 & ~r_dir;
  assign w_clr    = (w_commit && r_off == OffIrqStat) ? (w_gdata & w_gmask) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_off     <= '0;
      r_misal   <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
`ifdef GPIO_PROT_CHECK_EN
      r_priv    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_setup) begin
            r_off   <= bus.PADDR[4:2];
            r_misal <= bus.PADDR[1:0] != 2'b00;
            r_write <= bus.PWRITE;
            r_wdata <= bus.PWDATA;
            r_strb  <= bus.PSTRB;
`ifdef GPIO_PROT_CHECK_EN
            r_priv  <= bus.PPROT[0];
`endif
            if (WAIT_STATES == 0) begin
              r_pready  <= 1'b1;
              r_prdata  <= w_rdata;
              r_pslverr <= w_err;
              r_state   <= StDone;
            end else begin
              r_cnt   <= 4'(WAIT_STATES - 1);
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (!bus.PSEL) begin
            r_state <= StIdle;
          end else if (bus.PENABLE) begin
            if (r_cnt == 4'd0) begin
              r_pready  <= 1'b1;
              r_prdata  <= w_rdata;
              r_pslverr <= w_err;
              r_state   <= StDone;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        StDone: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dout     <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync3    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_commit && r_off == OffDout)  r_dout   <= (r_dout & ~w_gmask) | (w_gdata & w_gmask);
      if (w_commit && r_off == OffDir)   r_dir    <= (r_dir & ~w_gmask) | (w_gdata & w_gmask);
      if (w_commit && r_off == OffIrqEn) r_irq_en <= (r_irq_en & ~w_gmask) | (w_gdata & w_gmask);
      // A new edge in the same cycle as a W1C clear keeps the bit set.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;
  assign bus.PRDATA  = r_prdata;
  assign gpio_out    = r_dout;
  assign gpio_oe     = r_dir;
  assign irq         = r_irq;

  assign w_unused = ^{bus.PADDR[ADDR_WIDTH-1:5], bus.PPROT};

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Scoreboard bench for apb_gpio_slave: one instance with 1 wait state, one with 3.
module tb_apb_gpio_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, sel3 = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, gpio_in = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [31:0] out1, oe1, out3, oe3;
  logic        irq1, irq3;

  always #5 PCLK = ~PCLK;

  apb_gpio_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  apb_gpio_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus1.PSEL = psel & ~sel3;
  assign bus3.PSEL = psel & sel3;
  assign bus1.PENABLE = penable;  assign bus3.PENABLE = penable;
  assign bus1.PWRITE  = pwrite;   assign bus3.PWRITE  = pwrite;
  assign bus1.PADDR   = paddr;    assign bus3.PADDR   = paddr;
  assign bus1.PWDATA  = pwdata;   assign bus3.PWDATA  = pwdata;
  assign bus1.PSTRB   = pstrb;    assign bus3.PSTRB   = pstrb;
  assign bus1.PPROT   = pprot;    assign bus3.PPROT   = pprot;

  apb_gpio_slave #(.WAIT_STATES(1)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus1), .gpio_in(gpio_in),
    .gpio_out(out1), .gpio_oe(oe1), .irq(irq1)
  );
  apb_gpio_slave #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus3), .gpio_in(gpio_in),
    .gpio_out(out3), .gpio_oe(oe3), .irq(irq3)
  );

  logic        w_pready, w_pslverr;
  logic [31:0] w_prdata;
  assign w_pready  = sel3 ? bus3.PREADY  : bus1.PREADY;
  assign w_pslverr = sel3 ? bus3.PSLVERR : bus1.PSLVERR;
  assign w_prdata  = sel3 ? bus3.PRDATA  : bus1.PRDATA;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    bit          err;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

`ifdef GPIO_PROT_CHECK_EN
  localparam bit ProtOn = 1'b1;
`else
  localparam bit ProtOn = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed transfer.
  initial begin : monitor
    exp_t e;
    int   wcnt;
    wcnt = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        wcnt = 0;
      end else if (w_pready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pready: got 1, want 0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("pslverr", 64'(w_pslverr), 64'(e.err));
          if (e.chk) check("prdata", 64'(w_prdata), 64'(e.rdata));
          check("wait_cycles", 64'(wcnt), 64'(e.waits));
        end
        wcnt = 0;
      end else begin
        check("idle_outputs_zero", {31'd0, w_pslverr, w_prdata}, 64'd0);
        if (psel && penable) wcnt++;
        else if (!psel) wcnt = 0;
      end
    end
  end

  task automatic apb(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [2:0] prot,
                     input logic [31:0] erdata, input bit chk, input bit eerr);
    exp_t e;
    bit   done;
    e.rdata = erdata; e.chk = chk; e.err = eerr; e.waits = sel3 ? 3 : 1;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge PCLK); #1 penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (w_pready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pready_timeout: got 0, want 1 (addr %h)", addr);
      sb.delete();
    end
    @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                    input bit eerr);
    apb(addr, 1'b1, d, s, 3'b001, 32'h0, 1'b0, eerr);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input bit eerr);
    apb(addr, 1'b0, 32'h0, 4'h0, 3'b001, exp, 1'b1, eerr);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_pins_dut1", {out1, oe1}, 64'd0);
    check("reset_bus_dut1", {bus1.PREADY, bus1.PSLVERR, irq1, bus1.PRDATA}, 64'd0);
    check("reset_pins_dut3", {out3, oe3}, 64'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Basic write/readback with one wait state.
    wr(32'h04, 32'h0000_00FF, 4'hF, 1'b0);
    wr(32'h00, 32'hA5A5_A5A5, 4'hF, 1'b0);
    @(negedge PCLK);
    check("gpio_oe", 64'(oe1), 64'h0000_00FF);
    check("gpio_out", 64'(out1), 64'hA5A5_A5A5);
    @(posedge PCLK); #1;
    rd(32'h04, 32'h0000_00FF, 1'b0);
    rd(32'h00, 32'hA5A5_A5A5, 1'b0);

    // Byte strobes and the empty-strobe no-op.
    wr(32'h00, 32'h0000_0000, 4'hF, 1'b0);
    wr(32'h00, 32'h1234_5678, 4'b0010, 1'b0);
    rd(32'h00, 32'h0000_5600, 1'b0);
    wr(32'h00, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd(32'h00, 32'h0000_5600, 1'b0);

    // Error responses; bits 2..5 are outputs so no interrupt is raised here.
    gpio_in = 32'h0000_003C;
    repeat (3) @(posedge PCLK); #1;
    rd(32'h14, 32'h0, 1'b1);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(32'h08, 32'h0000_003C, 1'b0);
    rd(32'h02, 32'h0, 1'b1);
    gpio_in = 32'h0;
    repeat (4) @(posedge PCLK); #1;

    // Interrupt on a rising edge of pin 0.
    wr(32'h04, 32'h0, 4'hF, 1'b0);
    wr(32'h0C, 32'h1, 4'hF, 1'b0);
    gpio_in = 32'h1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("irq_before_reg", 64'(irq1), 64'd0);
    @(negedge PCLK);
    check("irq_asserted", 64'(irq1), 64'd1);
    @(posedge PCLK); #1;
    rd(32'h10, 32'h1, 1'b0);
    wr(32'h10, 32'h1, 4'hF, 1'b0);
    @(posedge PCLK);
    @(negedge PCLK);
    check("irq_cleared", 64'(irq1), 64'd0);
    @(posedge PCLK); #1;
    rd(32'h10, 32'h0, 1'b0);
    gpio_in = 32'h0;
    repeat (4) @(posedge PCLK); #1;
    // New edge lands on the same clock as the W1C commit.
    gpio_in = 32'h1;
    wr(32'h10, 32'h1, 4'hF, 1'b0);
    rd(32'h10, 32'h1, 1'b0);

    // Privilege check on DIR (rejected only when the option is built in).
    apb(32'h04, 1'b1, 32'h3, 4'hF, 3'b000, 32'h0, 1'b0, ProtOn);
    rd(32'h04, ProtOn ? 32'h0 : 32'h3, 1'b0);
    apb(32'h04, 1'b1, 32'hF, 4'hF, 3'b001, 32'h0, 1'b0, 1'b0);
    rd(32'h04, 32'hF, 1'b0);

    // Abort during wait states on the 3-wait instance.
    sel3 = 1'b1;
    wr(32'h00, 32'h11, 4'hF, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0;
    pwdata = 32'hFF; pstrb = 4'hF; pprot = 3'b001;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge PCLK); #1;
    check("abort_gpio_out", 64'(out3), 64'h11);
    rd(32'h00, 32'h11, 1'b0);
    sel3 = 1'b0;

    // Reset asserted in the middle of a transfer.
    gpio_in = 32'h0;
    repeat (4) @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK);
    check("pre_reset_irq", 64'(irq1), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("midreset_pins", {out1, oe1}, 64'd0);
    check("midreset_bus", {bus1.PREADY, bus1.PSLVERR, irq1, bus1.PRDATA}, 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd(32'h00, 32'h0, 1'b0);
    rd(32'h04, 32'h0, 1'b0);
    rd(32'h10, 32'h0, 1'b0);

    repeat (2) @(posedge PCLK);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
